core_seq_fsm: RTL

- Multi-cycle sequencer for the RV64 core datapath: fetch, decode, execute, memory, writeback.
- Drives a valid/ready instruction-fetch port and load/store port, and latches the instruction register feeding the decoder.
- Gates PC and register-file write enables so each instruction commits exactly once.
- Detects halt (ebreak), illegal instructions, bus errors and response timeouts; keeps cycle/instret counters.

---
 rtl/core_seq_fsm.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/core_seq_fsm.sv
// core_seq_fsm: multi-cycle sequencer for the RV64 core datapath.
// Steps each instruction through fetch, execute, optional memory access and
// writeback. It drives the fetch and load/store valid/ready ports, latches the
// instruction register, gates PC/RF commits to a single cycle per instruction,
// and traps on bus errors, illegal instructions or response timeouts.
// All outputs are registered. Each output register is loaded from a value
// computed from the next state, so the outputs line up with the state register.
module core_seq_fsm #(
    parameter int INST_W  = 32,
    parameter int CNT_W   = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              ifu_req_valid,
    input  logic              ifu_req_ready,
    input  logic              ifu_rsp_valid,
    input  logic [INST_W-1:0] ifu_rsp_inst,
    input  logic              ifu_rsp_err,
    output logic [INST_W-1:0] ir,
    input  logic              dec_is_mem,
    input  logic              dec_halt,
    input  logic              dec_illegal,
    output logic              lsu_req_valid,
    input  logic              lsu_req_ready,
    input  logic              lsu_rsp_valid,
    input  logic              lsu_rsp_err,
    output logic              pc_we,
    output logic              rf_we_en,
    output logic              halted,
    output logic              trap,
    output logic [2:0]        trap_cause,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt
);

    // Response wait budget. The counter is 16 bits, enough for any legal TIMEOUT.
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    // Trap cause encodings.
    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_FETCH   = 3'd1;
    localparam logic [2:0] CAUSE_ILLEGAL = 3'd2;
    localparam logic [2:0] CAUSE_TIMEOUT = 3'd3;
    localparam logic [2:0] CAUSE_LSU     = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_F_REQ  = 4'd1,
        ST_F_WAIT = 4'd2,
        ST_EXEC   = 4'd3,
        ST_M_REQ  = 4'd4,
        ST_M_WAIT = 4'd5,
        ST_WB     = 4'd6,
        ST_HALT   = 4'd7,
        ST_TRAP   = 4'd8
    } state_e;

    // The cycle counter runs in every state except IDLE, HALT and TRAP.
    function automatic logic is_active(input state_e st);
        logic act;
        case (st)
            ST_IDLE, ST_HALT, ST_TRAP: act = 1'b0;
            default:                   act = 1'b1;
        endcase
        return act;
    endfunction

    state_e              state_q, state_d;
    logic [15:0]         wait_q, wait_d;
    logic [15:0]         wait_inc_s;
    logic [INST_W-1:0]   ir_q, ir_d;
    logic [2:0]          cause_q, cause_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [CNT_W-1:0]    instret_q, instret_d;
    logic                retire_s;
    logic                ifu_req_valid_q, ifu_req_valid_d;
    logic                lsu_req_valid_q, lsu_req_valid_d;
    logic                pc_we_q, pc_we_d;
    logic                rf_we_en_q, rf_we_en_d;
    logic                halted_q, halted_d;
    logic                trap_q, trap_d;

    // Next-state logic: sequencing, wait counter, IR capture and trap cause.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        ir_d       = ir_q;
        cause_d    = cause_q;
        retire_s   = 1'b0;
        wait_inc_s = wait_q + 16'd1;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_F_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_F_REQ: begin
                // A response seen here is ignored; only the handshake matters.
                if (ifu_req_ready) begin
                    state_d = ST_F_WAIT;
                    wait_d  = 16'd0;
                end else begin
                    state_d = ST_F_REQ;
                end
            end
            ST_F_WAIT: begin
                if (ifu_rsp_valid) begin
                    if (ifu_rsp_err) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_FETCH;
                    end else begin
                        state_d = ST_EXEC;
                        ir_d    = ifu_rsp_inst;
                    end
                end else if (wait_inc_s == TIMEOUT_C) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_inc_s;
                end
            end
            ST_EXEC: begin
                // An illegal instruction wins over ebreak and memory decode.
                if (dec_illegal) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (dec_halt) begin
                    state_d  = ST_HALT;
                    retire_s = 1'b1;
                end else if (dec_is_mem) begin
                    state_d = ST_M_REQ;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_M_REQ: begin
                if (lsu_req_ready) begin
                    state_d = ST_M_WAIT;
                    wait_d  = 16'd0;
                end else begin
                    state_d = ST_M_REQ;
                end
            end
            ST_M_WAIT: begin
                if (lsu_rsp_valid) begin
                    if (lsu_rsp_err) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_LSU;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_inc_s == TIMEOUT_C) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_inc_s;
                end
            end
            ST_WB: begin
                retire_s = 1'b1;
                if (run) begin
                    state_d = ST_F_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                // Unreachable encodings fall back to a safe idle state.
                state_d = ST_IDLE;
                cause_d = CAUSE_NONE;
            end
        endcase
    end

    // Counters: active cycles and retired instructions, both wrapping.
    always_comb begin
        cycle_d   = cycle_q;
        instret_d = instret_q;
        if (is_active(state_q)) begin
            cycle_d = cycle_q + CNT_W'(1'b1);
        end else begin
            cycle_d = cycle_q;
        end
        if (retire_s) begin
            instret_d = instret_q + CNT_W'(1'b1);
        end else begin
            instret_d = instret_q;
        end
    end

    // Output decode from the next state so registered outputs track the state.
    always_comb begin
        ifu_req_valid_d = 1'b0;
        lsu_req_valid_d = 1'b0;
        pc_we_d         = 1'b0;
        rf_we_en_d      = 1'b0;
        halted_d        = 1'b0;
        trap_d          = 1'b0;
        case (state_d)
            ST_F_REQ: ifu_req_valid_d = 1'b1;
            ST_M_REQ: lsu_req_valid_d = 1'b1;
            ST_WB: begin
                pc_we_d    = 1'b1;
                rf_we_en_d = 1'b1;
            end
            ST_HALT:  halted_d = 1'b1;
            ST_TRAP:  trap_d   = 1'b1;
            default: begin
                ifu_req_valid_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            wait_q          <= 16'd0;
            ir_q            <= '0;
            cause_q         <= CAUSE_NONE;
            cycle_q         <= '0;
            instret_q       <= '0;
            ifu_req_valid_q <= 1'b0;
            lsu_req_valid_q <= 1'b0;
            pc_we_q         <= 1'b0;
            rf_we_en_q      <= 1'b0;
            halted_q        <= 1'b0;
            trap_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_q          <= wait_d;
            ir_q            <= ir_d;
            cause_q         <= cause_d;
            cycle_q         <= cycle_d;
            instret_q       <= instret_d;
            ifu_req_valid_q <= ifu_req_valid_d;
            lsu_req_valid_q <= lsu_req_valid_d;
            pc_we_q         <= pc_we_d;
            rf_we_en_q      <= rf_we_en_d;
            halted_q        <= halted_d;
            trap_q          <= trap_d;
        end
    end

    assign ifu_req_valid = ifu_req_valid_q;
    assign lsu_req_valid = lsu_req_valid_q;
    assign ir            = ir_q;
    assign pc_we         = pc_we_q;
    assign rf_we_en      = rf_we_en_q;
    assign halted        = halted_q;
    assign trap          = trap_q;
    assign trap_cause    = cause_q;
    assign cycle_cnt     = cycle_q;
    assign instret_cnt   = instret_q;

endmodule
